// File: rtl/gat_pkg.sv
// gat_pkg: shared target encodings, BRAM depths and loader state type for the GAT input path.
package gat_pkg;
  localparam int H_DATA_DEPTH     = 242101;
  localparam int NODE_INFO_DEPTH  = 13264;
  localparam int WEIGHT_DEPTH     = 22928;
  localparam int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH);
  localparam int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH);
  localparam int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH);
  localparam int LEN_W            = $clog2(H_DATA_DEPTH + 1);
  localparam logic [1:0] TGT_H_DATA    = 2'd0;
  localparam logic [1:0] TGT_NODE_INFO = 2'd1;
  localparam logic [1:0] TGT_WGT       = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH} state_t;
  // Illegal target reports depth 0 so any length is rejected against it.
  function automatic logic [LEN_W-1:0] depth_of(input logic [1:0] tgt);
    return tgt == TGT_H_DATA    ? LEN_W'(H_DATA_DEPTH) :
           tgt == TGT_NODE_INFO ? LEN_W'(NODE_INFO_DEPTH) :
           tgt == TGT_WGT       ? LEN_W'(WEIGHT_DEPTH) : '0;
  endfunction
endpackage

// File: rtl/gat_bram_loader_if.sv
// gat_bram_loader_if: host config/stream side and the three BRAM write ports of the loader.
interface gat_bram_loader_if;
  import gat_pkg::*;
  logic                      cfg_start;
  logic [1:0]                cfg_target;
  logic [LEN_W-1:0]          cfg_len;
  logic                      cfg_abort;
  logic                      cfg_clr_done;
  logic [31:0]               s_data;
  logic                      s_valid;
  logic                      s_last;
  logic                      s_ready;
  logic                      busy;
  logic                      err;
  logic [31:0]               h_data_bram_din;
  logic                      h_data_bram_ena;
  logic                      h_data_bram_wea;
  logic [H_DATA_ADDR_W+1:0]  h_data_bram_addra;
  logic [31:0]               h_node_info_bram_din;
  logic                      h_node_info_bram_ena;
  logic                      h_node_info_bram_wea;
  logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra;
  logic [31:0]               wgt_bram_din;
  logic                      wgt_bram_ena;
  logic                      wgt_bram_wea;
  logic [WEIGHT_ADDR_W+1:0]  wgt_bram_addra;
  logic                      h_data_bram_load_done;
  logic                      h_node_info_bram_load_done;
  logic                      wgt_bram_load_done;
  modport master (
    output cfg_start, cfg_target, cfg_len, cfg_abort, cfg_clr_done, s_data, s_valid, s_last,
    input  s_ready, busy, err,
    input  h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
    input  h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea, h_node_info_bram_addra,
    input  wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra,
    input  h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done
  );
  modport slave (
    input  cfg_start, cfg_target, cfg_len, cfg_abort, cfg_clr_done, s_data, s_valid, s_last,
    output s_ready, busy, err,
    output h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
    output h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea, h_node_info_bram_addra,
    output wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra,
    output h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done
  );
endinterface

// File: rtl/gat_bram_wr_port.sv
// gat_bram_wr_port: one registered BRAM write port; word index becomes a byte address.
module gat_bram_wr_port #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [31:0]       i_data,
  input  logic [ADDR_W-1:0] i_idx,
  output logic [31:0]       o_din,
  output logic              o_ena,
  output logic              o_wea,
  output logic [ADDR_W+1:0] o_addra
);
  logic [31:0]       r_din;
  logic              r_en;
  logic [ADDR_W+1:0] r_addra;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_din   <= '0;
      r_en    <= 1'b0;
      r_addra <= '0;
    end else begin
      r_en <= i_we;
      if (i_we) begin
        r_din   <= i_data;
        r_addra <= {i_idx, 2'b00};
      end
    end
  end
  assign o_din   = r_din;
  assign o_ena   = r_en;
  assign o_wea   = r_en;
  assign o_addra = r_addra;
endmodule

// File: rtl/gat_bram_loader.sv
// gat_bram_loader: steers one host word stream into the H data, node-info or weight BRAM
// and raises the per-BRAM load_done flags that gate the accelerator start.
module gat_bram_loader
  import gat_pkg::*;
(
  input logic             clk,
  input logic             rst,
  gat_bram_loader_if.slave bus
);
  state_t           r_state, w_next;
  logic [1:0]       r_tgt;
  logic [LEN_W-1:0] r_len, r_idx;
  logic             r_err, r_bad;
  logic [2:0]       r_done, w_done_set, w_done_clr;
  logic             w_hs, w_we, w_last_word, w_start_ok, w_accept, w_set_err;
  assign bus.s_ready = r_state == ST_LOAD && !bus.cfg_abort;
  assign bus.busy    = r_state != ST_IDLE;
  assign bus.err     = r_err;
  assign bus.h_data_bram_load_done      = r_done[TGT_H_DATA];
  assign bus.h_node_info_bram_load_done = r_done[TGT_NODE_INFO];
  assign bus.wgt_bram_load_done         = r_done[TGT_WGT];
  assign w_start_ok  = bus.cfg_len != '0 && bus.cfg_len <= depth_of(bus.cfg_target);
  assign w_hs        = bus.s_valid && bus.s_ready;
  assign w_last_word = r_idx == r_len - LEN_W'(1);
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_we      = 1'b0;
    w_set_err = 1'b0;
    if (bus.cfg_abort) w_next = ST_IDLE;
    else case (r_state)
      ST_IDLE: if (bus.cfg_start) begin
        w_accept  = w_start_ok;
        w_set_err = !w_start_ok;
        w_next    = w_start_ok ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: if (w_hs) begin
        w_we      = 1'b1;
        w_set_err = w_last_word ? !bus.s_last : bus.s_last;
        w_next    = w_last_word ? ST_FLUSH : bus.s_last ? ST_IDLE : ST_LOAD;
      end
      ST_FLUSH: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end
  // A FLUSH set beats a same-cycle clear; an abort during FLUSH suppresses the set.
  assign w_done_set = (r_state == ST_FLUSH && !r_bad && !bus.cfg_abort) ? 3'b001 << r_tgt : 3'b000;
  assign w_done_clr = {3{bus.cfg_clr_done}} | (w_accept ? 3'b001 << bus.cfg_target : 3'b000);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tgt   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_bad   <= 1'b0;
      r_done  <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_set_err | (r_err & !bus.cfg_clr_done);
      r_done  <= w_done_set | (r_done & ~w_done_clr);
      if (w_accept) begin
        r_tgt <= bus.cfg_target;
        r_len <= bus.cfg_len;
        r_idx <= '0;
        r_bad <= 1'b0;
      end else if (w_we) begin
        r_idx <= r_idx + LEN_W'(1);
        r_bad <= r_bad | (w_last_word & !bus.s_last);
      end
    end
  end
  gat_bram_wr_port #(.ADDR_W(H_DATA_ADDR_W)) u_h_data (
    .clk(clk), .rst(rst),
    .i_we(w_we && r_tgt == TGT_H_DATA), .i_data(bus.s_data), .i_idx(r_idx[H_DATA_ADDR_W-1:0]),
    .o_din(bus.h_data_bram_din), .o_ena(bus.h_data_bram_ena),
    .o_wea(bus.h_data_bram_wea), .o_addra(bus.h_data_bram_addra)
  );
  gat_bram_wr_port #(.ADDR_W(NODE_INFO_ADDR_W)) u_node_info (
    .clk(clk), .rst(rst),
    .i_we(w_we && r_tgt == TGT_NODE_INFO), .i_data(bus.s_data), .i_idx(r_idx[NODE_INFO_ADDR_W-1:0]),
    .o_din(bus.h_node_info_bram_din), .o_ena(bus.h_node_info_bram_ena),
    .o_wea(bus.h_node_info_bram_wea), .o_addra(bus.h_node_info_bram_addra)
  );
  gat_bram_wr_port #(.ADDR_W(WEIGHT_ADDR_W)) u_wgt (
    .clk(clk), .rst(rst),
    .i_we(w_we && r_tgt == TGT_WGT), .i_data(bus.s_data), .i_idx(r_idx[WEIGHT_ADDR_W-1:0]),
    .o_din(bus.wgt_bram_din), .o_ena(bus.wgt_bram_ena),
    .o_wea(bus.wgt_bram_wea), .o_addra(bus.wgt_bram_addra)
  );
endmodule

// File: tb/tb_gat_bram_loader.sv
// tb_gat_bram_loader: directed and randomized loads checked against a write-log reference model.
module tb_gat_bram_loader;
  import gat_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gat_bram_loader_if bus();
  gat_bram_loader dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [54:0] wq[$];
  int wc[$];
  int rise[3];
  logic [2:0] prev_done = 3'b000;
  bit busy_seen = 1'b0;
  int dep[4] = '{H_DATA_DEPTH, NODE_INFO_DEPTH, WEIGHT_DEPTH, 0};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : mon
    logic [2:0] d;
    if (bus.h_data_bram_ena) begin
      wq.push_back({bus.h_data_bram_wea, 2'd0, 20'(bus.h_data_bram_addra), bus.h_data_bram_din});
      wc.push_back(cyc);
    end
    if (bus.h_node_info_bram_ena) begin
      wq.push_back({bus.h_node_info_bram_wea, 2'd1, 20'(bus.h_node_info_bram_addra), bus.h_node_info_bram_din});
      wc.push_back(cyc);
    end
    if (bus.wgt_bram_ena) begin
      wq.push_back({bus.wgt_bram_wea, 2'd2, 20'(bus.wgt_bram_addra), bus.wgt_bram_din});
      wc.push_back(cyc);
    end
    d = {bus.wgt_bram_load_done, bus.h_node_info_bram_load_done, bus.h_data_bram_load_done};
    for (int k = 0; k < 3; k++) if (d[k] && !prev_done[k]) rise[k] = cyc;
    prev_done = d;
    if (bus.busy) busy_seen = 1'b1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic chk_zero(input string pfx);
    chk({pfx, "_ctl"}, {bus.s_ready, bus.busy, bus.err, bus.h_data_bram_load_done,
        bus.h_node_info_bram_load_done, bus.wgt_bram_load_done, bus.h_data_bram_ena, bus.h_data_bram_wea,
        bus.h_node_info_bram_ena, bus.h_node_info_bram_wea, bus.wgt_bram_ena, bus.wgt_bram_wea}, 0);
    chk({pfx, "_addr"}, {bus.h_data_bram_addra, bus.h_node_info_bram_addra, bus.wgt_bram_addra}, 0);
    chk({pfx, "_din_a"}, {bus.h_data_bram_din, bus.h_node_info_bram_din}, 0);
    chk({pfx, "_din_b"}, bus.wgt_bram_din, 0);
  endtask
  task automatic done_bits(output logic [2:0] d);
    d = {bus.wgt_bram_load_done, bus.h_node_info_bram_load_done, bus.h_data_bram_load_done};
  endtask
  // Model: a legal load writes words up to the first s_last or len words, whichever comes first;
  // it is clean (done, no err) only when s_last lands exactly on word len-1.
  task automatic run_load(input int tgt, input int len, input int last_at, input int gap,
                          input int base, input bit clr_in_flush);
    logic [54:0] eq[$];
    logic [31:0] d;
    logic [2:0] dn;
    int n;
    bit ok, e_err, e_done;
    bus.cfg_clr_done = 1'b1;
    tick;
    bus.cfg_clr_done = 1'b0;
    chk("clr_err", bus.err, 0);
    wq.delete();
    wc.delete();
    busy_seen = 1'b0;
    ok = tgt < 3 && len >= 1 && len <= dep[tgt];
    n = ok ? (last_at >= 0 && last_at < len ? last_at + 1 : len) : 0;
    e_err = !ok || last_at != len - 1;
    e_done = !e_err;
    bus.cfg_target = 2'(tgt);
    bus.cfg_len = LEN_W'(len);
    bus.cfg_start = 1'b1;
    tick;
    bus.cfg_start = 1'b0;
    for (int i = 0; i < (ok ? n : 2); i++) begin
      if (gap == 1 && i > 0) begin
        bus.s_valid = 1'b0;
        tick;
      end
      if (gap == 2) while ($urandom_range(0, 2) == 0) begin
        bus.s_valid = 1'b0;
        tick;
      end
      d = base != 0 ? 32'(base + i) : $urandom;
      bus.s_valid = 1'b1;
      bus.s_data = d;
      bus.s_last = i == last_at;
      tick;
      if (ok) eq.push_back({1'b1, 2'(tgt), 20'(i * 4), d});
    end
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.cfg_clr_done = clr_in_flush;
    tick;
    bus.cfg_clr_done = 1'b0;
    for (int t = 0; t < 20 && bus.busy; t++) tick;
    chk("idle", bus.busy, 0);
    tick;
    chk($sformatf("nwr_t%0d_l%0d", tgt, len), wq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < wq.size(); i++) chk($sformatf("wr%0d_t%0d", i, tgt), wq[i], eq[i]);
    chk($sformatf("err_t%0d_l%0d", tgt, len), bus.err, e_err);
    done_bits(dn);
    chk($sformatf("done_t%0d_l%0d", tgt, len), dn, e_done ? 3'(1 << tgt) : 3'b000);
    chk("busy_seen", busy_seen, ok);
  endtask
  initial begin : wdog
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [2:0] dn;
    int tgt, len, la;
    bus.cfg_start = 1'b0;
    bus.cfg_target = 2'd0;
    bus.cfg_len = '0;
    bus.cfg_abort = 1'b0;
    bus.cfg_clr_done = 1'b0;
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    repeat (2) tick;
    chk_zero("reset");
    rst = 1'b0;
    tick;
    run_load(2, 4, 3, 0, 'hA0, 1'b0);
    if (wc.size() == 4) begin
      for (int i = 1; i < 4; i++) chk($sformatf("b2b_cyc%0d", i), wc[i], wc[0] + i);
      chk("done_rise", rise[2], wc[3] + 1);
    end
    run_load(0, 3, 1, 0, 0, 1'b0);
    run_load(1, NODE_INFO_DEPTH + 1, NODE_INFO_DEPTH, 0, 0, 1'b0);
    run_load(1, 5, 4, 1, 0, 1'b0);
    run_load(3, 2, 1, 0, 0, 1'b0);
    run_load(2, 0, 0, 0, 0, 1'b0);
    run_load(0, 3, 5, 0, 0, 1'b0);
    run_load(0, 1, 0, 0, 0, 1'b1);
    run_load(1, NODE_INFO_DEPTH, NODE_INFO_DEPTH - 1, 0, 0, 1'b0);
    bus.cfg_clr_done = 1'b1;
    tick;
    bus.cfg_clr_done = 1'b0;
    wq.delete();
    bus.cfg_target = 2'd2;
    bus.cfg_len = LEN_W'(8);
    bus.cfg_start = 1'b1;
    tick;
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = $urandom;
      tick;
    end
    bus.s_valid = 1'b0;
    bus.cfg_abort = 1'b1;
    tick;
    bus.cfg_abort = 1'b0;
    chk("abort_ready", bus.s_ready, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (3) tick;
    chk("abort_nwr", wq.size(), 2);
    chk("abort_done", bus.wgt_bram_load_done, 0);
    chk("abort_err", bus.err, 0);
    run_load(2, 8, 7, 0, 0, 1'b0);
    for (int r = 0; r < 14; r++) begin
      tgt = $urandom_range(0, 3);
      len = $urandom_range(0, 9);
      la = $urandom_range(0, 9) < 7 ? len - 1 : $urandom_range(0, len + 1);
      run_load(tgt, len, la, 2, 0, 1'b0);
    end
    run_load(2, 2, 1, 0, 0, 1'b0);
    bus.cfg_target = 2'd0;
    bus.cfg_len = LEN_W'(10);
    bus.cfg_start = 1'b1;
    tick;
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = $urandom;
      tick;
    end
    chk("pre_rst_busy", bus.busy, 1);
    chk("pre_rst_ena", bus.h_data_bram_ena, 1);
    done_bits(dn);
    chk("pre_rst_done", dn, 3'b100);
    #1 rst = 1'b1;
    #1 chk_zero("rst_mid");
    bus.s_valid = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_busy", bus.busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
